// File: rtl/pwm_pkg.sv
// Shared types and reset defaults for the PWM output path and its register block.
package pwm_pkg;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_HI  = 2'd1,
    S_LO  = 2'd2,
    S_DT  = 2'd3
  } pwm_state_t;

  localparam int unsigned DT_W_DEFAULT = 16;

  // Reset defaults; gate values are internal (pre-polarity) levels.
  localparam pwm_state_t RST_STATE         = S_OFF;
  localparam logic       RST_PWM_Q         = 1'b0;
  localparam logic       RST_GATE          = 1'b0;
  localparam logic       RST_DT_ACTIVE     = 1'b0;
  localparam logic       RST_PULSE_DROPPED = 1'b0;
  localparam logic       RST_ENABLE        = 1'b0;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// Signal bundle between the PWM core/control registers and the dead-time generator.
interface pwm_deadtime_gen_if #(
  parameter int unsigned DT_W = pwm_pkg::DT_W_DEFAULT
);
  logic            pwm_in;
  logic            enable;
  logic [DT_W-1:0] dead_time;
  logic            clr_drop;
  logic            coe_pwm_hi;
  logic            coe_pwm_lo;
  logic            dt_active;
  logic            pulse_dropped;

  modport master (
    output pwm_in, enable, dead_time, clr_drop,
    input  coe_pwm_hi, coe_pwm_lo, dt_active, pulse_dropped
  );

  modport slave (
    input  pwm_in, enable, dead_time, clr_drop,
    output coe_pwm_hi, coe_pwm_lo, dt_active, pulse_dropped
  );
endinterface

// File: rtl/pwm_deadtime_gen_dt_counter.sv
// Loadable down-counter for the dead interval; a zero load value counts as one cycle.
module dt_counter #(
  parameter int unsigned DT_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            dec_i,
  input  logic [DT_W-1:0] load_val_i,
  output logic            expired_o
);
  localparam logic [DT_W-1:0] ONE = {{(DT_W-1){1'b0}}, 1'b1};

  logic [DT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = (load_val_i == '0) ? ONE : load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == ONE);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive generator with programmable dead time and a sticky
// dropped-pulse flag. Gate outputs are registered from the next-state decode.
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W            = DT_W_DEFAULT,
  parameter bit          OUT_ACTIVE_HIGH = 1'b1
) (
  input  logic               csi_clk,
  input  logic               rsi_rst,
  pwm_deadtime_gen_if.slave  bus
);
  localparam logic OFF_LVL = RST_GATE ~^ OUT_ACTIVE_HIGH;

  pwm_state_t state_q, state_d;
  logic       pwm_q;
  logic       hi_q, lo_q, dt_q, drop_q;
  logic       cnt_load, cnt_dec, cnt_clr, cnt_exp;
  logic       drop_set;

  dt_counter #(
    .DT_W (DT_W)
  ) u_dt_counter (
    .clk_i      (csi_clk),
    .rst_i      (rsi_rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (bus.dead_time),
    .expired_o  (cnt_exp)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    if (!bus.enable) begin
      state_d = S_OFF;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_d  = S_DT;
          cnt_load = 1'b1;
        end
        S_HI: if (!pwm_q) begin
          state_d  = S_DT;
          cnt_load = 1'b1;
        end
        S_LO: if (pwm_q) begin
          state_d  = S_DT;
          cnt_load = 1'b1;
        end
        S_DT: begin
          cnt_dec = 1'b1;
          // The interval always runs to completion; pwm_q only picks the exit side.
          if (cnt_exp) state_d = pwm_q ? S_HI : S_LO;
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  assign drop_set = (state_q == S_DT) && (pwm_q != bus.pwm_in);

  always_ff @(posedge csi_clk) begin
    if (rsi_rst) begin
      state_q <= RST_STATE;
      pwm_q   <= RST_PWM_Q;
      hi_q    <= OFF_LVL;
      lo_q    <= OFF_LVL;
      dt_q    <= RST_DT_ACTIVE;
      drop_q  <= RST_PULSE_DROPPED;
    end else begin
      state_q <= state_d;
      pwm_q   <= bus.pwm_in;
      hi_q    <= (state_d == S_HI) ~^ OUT_ACTIVE_HIGH;
      lo_q    <= (state_d == S_LO) ~^ OUT_ACTIVE_HIGH;
      dt_q    <= (state_d == S_DT);
      if (drop_set) begin
        drop_q <= 1'b1;
      end else if (bus.clr_drop) begin
        drop_q <= 1'b0;
      end
    end
  end

  assign bus.coe_pwm_hi    = hi_q;
  assign bus.coe_pwm_lo    = lo_q;
  assign bus.dt_active     = dt_q;
  assign bus.pulse_dropped = drop_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed and randomized bench for pwm_deadtime_gen, both output polarities side by side.
module tb_pwm_deadtime_gen;
  localparam int unsigned DT_W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pin = 1'b0;
  logic            en  = 1'b0;
  logic            clr = 1'b0;
  logic [DT_W-1:0] dt  = '0;

  int n_assert = 0;
  int n_fail   = 0;

  pwm_deadtime_gen_if #(.DT_W(DT_W)) ifa ();
  pwm_deadtime_gen_if #(.DT_W(DT_W)) ifb ();

  assign ifa.pwm_in = pin;  assign ifb.pwm_in = pin;
  assign ifa.enable = en;   assign ifb.enable = en;
  assign ifa.dead_time = dt; assign ifb.dead_time = dt;
  assign ifa.clr_drop = clr; assign ifb.clr_drop = clr;

  pwm_deadtime_gen #(.DT_W(DT_W), .OUT_ACTIVE_HIGH(1'b1)) dut_a (
    .csi_clk (clk), .rsi_rst (rst), .bus (ifa.slave));
  pwm_deadtime_gen #(.DT_W(DT_W), .OUT_ACTIVE_HIGH(1'b0)) dut_b (
    .csi_clk (clk), .rsi_rst (rst), .bus (ifb.slave));

  always #5 clk = ~clk;

  // Reference: which side conducts (0 none, 1 high, 2 low, 3 dead gap) and the
  // absolute edge number at which the current gap ends.
  int m_side = 0;
  int m_gap_end = 0;
  int m_edge = 0;
  bit m_pq = 1'b0;
  bit m_drop = 1'b0;

  function automatic void model_edge();
    int d;
    m_edge++;
    if (rst) begin
      m_side = 0; m_pq = 1'b0; m_drop = 1'b0;
      return;
    end
    if (m_side == 3 && (m_pq != pin)) m_drop = 1'b1;
    else if (clr) m_drop = 1'b0;
    d = (dt == 0) ? 1 : int'(dt);
    if (!en) m_side = 0;
    else if (m_side == 0 || (m_side == 1 && !m_pq) || (m_side == 2 && m_pq)) begin
      m_side = 3;
      m_gap_end = m_edge + d;
    end else if (m_side == 3 && m_edge == m_gap_end) m_side = m_pq ? 1 : 2;
    m_pq = pin;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic e_hi, e_lo;
    @(posedge clk);
    model_edge();
    #1;
    e_hi = (m_side == 1);
    e_lo = (m_side == 2);
    chk("hi_a", ifa.coe_pwm_hi, e_hi);
    chk("lo_a", ifa.coe_pwm_lo, e_lo);
    chk("dt_a", ifa.dt_active, m_side == 3);
    chk("drop_a", ifa.pulse_dropped, m_drop);
    chk("hi_b", ifb.coe_pwm_hi, !e_hi);
    chk("lo_b", ifb.coe_pwm_lo, !e_lo);
    chk("dt_b", ifb.dt_active, m_side == 3);
    chk("drop_b", ifb.pulse_dropped, m_drop);
    chk("excl_a", ifa.coe_pwm_hi & ifa.coe_pwm_lo, 1'b0);
    chk("excl_b", ifb.coe_pwm_hi | ifb.coe_pwm_lo, 1'b1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int first_hi, n_dt, n_hi, n_lo;

    // Reset release straight into an enabled, high PWM input.
    rst = 1'b1; en = 1'b1; pin = 1'b1; dt = 16'd4;
    steps(3);
    rst = 1'b0;
    first_hi = -1; n_dt = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (ifa.coe_pwm_hi && first_hi < 0) first_hi = k;
      if (ifa.dt_active) n_dt++;
    end
    chk_i("rst_rel_edges_to_hi", first_hi, 5);
    chk_i("rst_rel_dead_cycles", n_dt, 4);

    // Steady 20-cycle period, 50% duty, dead time 3.
    dt = 16'd3;
    for (int p = 0; p < 3; p++) begin
      n_hi = 0; n_lo = 0; n_dt = 0;
      for (int c = 0; c < 20; c++) begin
        pin = (c < 10);
        step();
        n_hi += int'(ifa.coe_pwm_hi);
        n_lo += int'(ifa.coe_pwm_lo);
        n_dt += int'(ifa.dt_active);
      end
    end
    chk_i("steady_hi_cycles", n_hi, 7);
    chk_i("steady_lo_cycles", n_lo, 7);
    chk_i("steady_dead_cycles", n_dt, 6);

    // Zero dead time behaves as a single dead cycle per transition.
    dt = '0;
    for (int p = 0; p < 3; p++) begin
      n_dt = 0;
      for (int c = 0; c < 8; c++) begin
        pin = (c < 4);
        step();
        n_dt += int'(ifa.dt_active);
      end
    end
    chk_i("dt0_dead_cycles", n_dt, 2);

    // Short glitch while low-side conducts.
    dt = 16'd5; pin = 1'b0;
    steps(12);
    pin = 1'b1; steps(2);
    pin = 1'b0; steps(12);
    chk("glitch_lo_back", ifa.coe_pwm_lo, 1'b1);
    chk("glitch_dropped", ifa.pulse_dropped, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("glitch_cleared", ifa.pulse_dropped, 1'b0);

    // Disable mid high-side, then mid dead interval.
    pin = 1'b1; steps(10);
    en = 1'b0; step();
    chk("dis_hi_off", ifa.coe_pwm_hi, 1'b0);
    en = 1'b1; steps(8);
    pin = 1'b0; steps(2);
    en = 1'b0; step();
    chk("dis_dt_off", ifa.dt_active, 1'b0);
    en = 1'b1; steps(8);

    // Maximum dead time must not wrap to an early exit.
    dt = '1; pin = 1'b1; steps(3);
    pin = 1'b0; steps(40);
    chk("dtmax_still_dead", ifa.dt_active, 1'b1);
    en = 1'b0; step();
    en = 1'b1; dt = 16'd3; steps(10);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(5) == 0) pin = ~pin;
      en  = ($urandom_range(39) != 0);
      clr = ($urandom_range(9) == 0);
      rst = ($urandom_range(149) == 0);
      if ($urandom_range(7) == 0) dt = DT_W'($urandom_range(4));
      step();
    end
    rst = 1'b0; clr = 1'b0; en = 1'b1;
    steps(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
